sram_rmw_bridge: RTL and testbench

- Sits directly upstream of the word-only data SRAM, between the CPU load/store unit and the SRAM's HSEL/HADDR/HWRITE/HWDATA/HRDATA port.
- Converts byte, halfword and word loads/stores into word-aligned SRAM cycles. Sub-word stores use a read-modify-write sequence.
- Extracts and sign/zero-extends load data.
- Returns one registered response per accepted request.

---
 rtl/sram_bridge_pkg.sv | 20 ++
 rtl/sram_lane_unit.sv | 38 +++
 rtl/sram_rmw_bridge.sv | 147 ++++++++++++++
 tb/tb_sram_rmw_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and defaults for the SRAM read-modify-write bridge.
package sram_bridge_pkg;

  localparam int DEPTH_WORDS_DEF = 8192;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/sram_lane_unit.sv
// Combinational lane logic: extracts/extends a load field from a word and
// merges store data into a word for the read-modify-write path.
module sram_lane_unit
  import sram_bridge_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  size_t       size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    rdata_o  = word_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        rdata_o  = {{24{~uns_i & byte_sel[7]}}, byte_sel};
        merged_o = word_i;
        merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        rdata_o  = {{16{~uns_i & half_sel[15]}}, half_sel};
        merged_o = addr_lo_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                : {word_i[31:16], wdata_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_rmw_bridge.sv
// CPU load/store to word-only SRAM bridge with read-modify-write for sub-word
// stores. Define SRAM_RMW_MISALIGN_CHECK_EN to reject misaligned half/word ops.
module sram_rmw_bridge
  import sram_bridge_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              HSEL,
  output logic [31:0]       HADDR,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  size_t             size_q;
  logic              uns_q;
  logic [31:0]       buf_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic              accept;
  logic              misalign;
  logic              req_err;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       lane_rdata;
  logic [31:0]       lane_merged;

  assign word_idx = req_addr >> 2;

`ifdef SRAM_RMW_MISALIGN_CHECK_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == SZ_RSVD) || (word_idx >= ADDR_W'(DEPTH_WORDS)) || misalign;
  assign accept  = req_valid && req_ready;

  assign HADDR      = 32'({addr_q[ADDR_W-1:2], 2'b00});
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // buf_q holds the store data until READ overwrites it with the merged word
  sram_lane_unit u_lane (
    .word_i    (HRDATA),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .wdata_i   (buf_q),
    .rdata_o   (lane_rdata),
    .merged_o  (lane_merged)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    HSEL       = 1'b0;
    HWRITE     = 1'b0;
    HWDATA     = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                            state_d = RESP;
          else if (req_we && req_size == SZ_WORD) state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ: begin
        HSEL    = 1'b1;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        HSEL    = 1'b1;
        HWRITE  = 1'b1;
        HWDATA  = buf_q;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers only change on the cycle that leads into RESP
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      buf_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        we_q   <= req_we;
        size_q <= size_t'(req_size);
        uns_q  <= req_unsigned;
        buf_q  <= req_wdata;
        if (req_err) begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b1;
        end
      end
      if (state_q == READ) begin
        if (we_q) begin
          buf_q <= lane_merged;
        end else begin
          resp_rdata_q <= lane_rdata;
          resp_err_q   <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_rmw_bridge.sv
// Self-checking bench for sram_rmw_bridge: directed vector table, reset-abort
// sequence and randomized traffic against a word-array reference model.
module tb_sram_rmw_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sram    [0:8191];
  logic [31:0] ref_mem [0:8191];

  always #5 HCLK = ~HCLK;

  assign HRDATA = sram[HADDR[14:2]];
  always @(posedge HCLK) if (HSEL && HWRITE) sram[HADDR[14:2]] <= HWDATA;

  sram_rmw_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: word array plus shift/mask arithmetic derived from the lane rules.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int nrd, output int nwr);
    int unsigned idx, sh;
    logic [31:0] w, f, m;
    idx = addr / 4;
    er  = (sz == 2'd3) || (idx >= 8192);
`ifdef SRAM_RMW_MISALIGN_CHECK_EN
    if (sz == 2'd1 && (addr % 2) != 0) er = 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) er = 1'b1;
`endif
    rd = '0; lat = 1; nrd = 0; nwr = 0;
    if (!er) begin
      w  = ref_mem[idx];
      sh = (sz == 2'd0) ? 8 * (addr % 4) : (sz == 2'd1) ? 16 * ((addr / 2) % 2) : 0;
      m  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (we) begin
        ref_mem[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
        nwr = 1;
        nrd = (sz == 2'd2) ? 0 : 1;
        lat = (sz == 2'd2) ? 2 : 3;
      end else begin
        f = (w >> sh) & m;
        if (!uns && sz != 2'd2 && f[(sz == 2'd0) ? 7 : 15]) f = f | ~m;
        rd = f; nrd = 1; lat = 2;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nrd, output int nwr);
    bit done = 0;
    bit bad_ready = 0;
    bit bad_addr = 0;
    rd = '0; er = 1'b0; lat = -1; nrd = 0; nwr = 0;
    @(negedge HCLK);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge HCLK);
    #1;
    // Garbage held on the inputs while busy must be ignored
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge HCLK);
      if (req_ready) bad_ready = 1;
      if (HSEL) begin
        if (HWRITE) nwr++; else nrd++;
        if (HADDR !== {addr[31:2], 2'b00}) bad_addr = 1;
      end
      if (resp_valid) begin
        done = 1; lat = c; rd = resp_rdata; er = resp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk({tag, " busy-ready"}, 32'(bad_ready), 32'd0);
    chk({tag, " haddr"}, 32'(bad_addr), 32'd0);
    if (done) begin
      @(negedge HCLK);
      chk({tag, " pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, " hold"}, {resp_rdata[30:0], resp_err}, {rd[30:0], er});
    end
  endtask

  logic [31:0] g_rd, e_rd;
  logic        g_er, e_er;
  int          g_lat, g_nrd, g_nwr, e_lat, e_nrd, e_nwr;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h1002, 32'h00000055, 32'h0,        1'b0, 3, 1, 1};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'hDE55BEEF, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        32'h000000DE, 1'b0, 2, 1, 0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h1000, 32'h00008001, 32'h0,        1'b0, 3, 1, 1};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h1000, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h1002, 32'h0,        32'h0000DE55, 1'b0, 2, 1, 0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h8000, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 32'h1000, 32'h12345678, 32'h0,        1'b1, 1, 0, 0};
    vecs[12] = '{1'b1, 2'd0, 1'b0, 32'h1001, 32'hFFFFFFAB, 32'h0,        1'b0, 3, 1, 1};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'hDE55AB01, 1'b0, 2, 1, 0};
`ifdef SRAM_RMW_MISALIGN_CHECK_EN
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h1001, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h1003, 32'h0,        32'h0,        1'b1, 1, 0, 0};
`else
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h1001, 32'h0,        32'hDE55AB01, 1'b0, 2, 1, 0};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h1003, 32'h0,        32'hFFFFDE55, 1'b0, 2, 1, 0};
`endif

    // Reset values while HRESET is held
    repeat (2) @(negedge HCLK);
    chk("rst HSEL", 32'(HSEL), 32'd0);
    chk("rst HWRITE", 32'(HWRITE), 32'd0);
    chk("rst HADDR", HADDR, 32'h0);
    chk("rst HWDATA", HWDATA, 32'h0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      run_req(t, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
              g_rd, g_er, g_lat, g_nrd, g_nwr);
      model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
            e_rd, e_er, e_lat, e_nrd, e_nwr);
      chk({t, " rdata"}, g_rd, vecs[i].exp_rd);
      chk({t, " err"}, 32'(g_er), 32'(vecs[i].exp_er));
      chk({t, " latency"}, 32'(g_lat), 32'(vecs[i].exp_lat));
      chk({t, " reads"}, 32'(g_nrd), 32'(vecs[i].exp_nrd));
      chk({t, " writes"}, 32'(g_nwr), 32'(vecs[i].exp_nwr));
    end

    // Reset during the WRITE of a byte store must leave memory untouched
    run_req("prime", 1'b1, 2'd2, 1'b0, 32'h2000, 32'h11223344, g_rd, g_er, g_lat, g_nrd, g_nwr);
    model(1'b1, 2'd2, 1'b0, 32'h2000, 32'h11223344, e_rd, e_er, e_lat, e_nrd, e_nwr);
    begin
      bit seen = 0;
      int nresp = 0;
      @(negedge HCLK);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h2000; req_wdata = 32'h99;
      @(posedge HCLK);
      #1 req_valid = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
        @(negedge HCLK);
        if (resp_valid) nresp++;
        if (HSEL && HWRITE) seen = 1;
      end
      chk("abort reached WRITE", 32'(seen), 32'd1);
      HRESET = 1'b1;
      #1;
      chk("abort HSEL", 32'(HSEL), 32'd0);
      chk("abort HWRITE", 32'(HWRITE), 32'd0);
      @(negedge HCLK);
      HRESET = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge HCLK);
        if (resp_valid) nresp++;
      end
      chk("abort no resp", 32'(nresp), 32'd0);
    end
    run_req("after abort", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, g_rd, g_er, g_lat, g_nrd, g_nwr);
    chk("after abort rdata", g_rd, 32'h11223344);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] addr, wd;
      int          r;
      string       t;
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom);
      wd  = $urandom;
      r   = $urandom_range(0, 15);
      if (r == 0)      addr = 32'h8000 + $urandom_range(0, 4095);
      else if (r == 1) addr = $urandom | 32'h8000_0000;
      else             addr = 32'h1000 + $urandom_range(0, 31);
      t = $sformatf("rnd%0d", i);
      run_req(t, we, sz, uns, addr, wd, g_rd, g_er, g_lat, g_nrd, g_nwr);
      model(we, sz, uns, addr, wd, e_rd, e_er, e_lat, e_nrd, e_nwr);
      chk({t, " rdata"}, g_rd, e_rd);
      chk({t, " err"}, 32'(g_er), 32'(e_er));
      chk({t, " latency"}, 32'(g_lat), 32'(e_lat));
      chk({t, " reads"}, 32'(g_nrd), 32'(e_nrd));
      chk({t, " writes"}, 32'(g_nwr), 32'(e_nwr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
